// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic-unit blocks.
// FSM encodings, default operand width and counter sizing.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 4;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_restoring_divider_ripple_subtractor.sv
// Combinational a - b as a + ~b + 1 over a chain of full-adder cells.
// borrow is high when a < b (unsigned).
module ripple_subtractor #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  logic [N:0]   c;
  logic [N-1:0] bn;

  assign bn   = ~b;
  assign c[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign diff[i] = a[i] ^ bn[i] ^ c[i];
    assign c[i+1]  = (a[i] & bn[i]) | (c[i] & (a[i] ^ bn[i]));
  end

  assign borrow = ~c[N];

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// start/done handshake; divide-by-zero completes in a single cycle.
module seq_restoring_divider
  import arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] q_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic             dbz_q;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic             neg;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] q_d;

  // R stays below the divisor, so only WIDTH bits need storing.
  assign r_sh = {r_q, q_q[WIDTH-1]};

  ripple_subtractor #(
    .N(WIDTH + 1)
  ) u_sub (
    .a     (r_sh),
    .b     ({1'b0, dvs_q}),
    .diff  (trial),
    .borrow(borrow)
  );

  assign neg = trial[WIDTH] | borrow;
  assign r_d = neg ? r_sh[WIDTH-1:0] : trial[WIDTH-1:0];
  assign q_d = {q_q[WIDTH-2:0], ~neg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dvs_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (start && divisor == '0) begin
            quo_q   <= '1;
            rem_q   <= dividend;
            dbz_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (start) begin
            dvs_q   <= divisor;
            r_q     <= '0;
            q_q     <= dividend;
            cnt_q   <= CW'(WIDTH);
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            quo_q   <= q_d;
            rem_q   <= r_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider at WIDTH=4.
// Stimulus pushes expected results; a negedge monitor pops on done.
module tb_seq_restoring_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", int'(done), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", int'(quotient), int'(e.q));
        check("remainder", int'(remainder), int'(e.r));
        check("div_by_zero", int'(div_by_zero), int'(e.dbz));
        check("done_cycle", cyc, e.cyc);
        check("busy_in_done", int'(busy), 0);
      end
    end
  end

  // Called at a negedge; the request is accepted at the next posedge.
  task automatic push_op(input int a, input int b, input int q,
                         input int r, input int dbz);
    exp_t e;
    start    = 1'b1;
    dividend = W'(a);
    divisor  = W'(b);
    e.q   = W'(q);
    e.r   = W'(r);
    e.dbz = dbz[0];
    e.cyc = cyc + 1 + ((b == 0) ? 0 : W);
    sb.push_back(e);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20; i++) begin
      if (done) return;
      @(negedge clk);
    end
    check("done_timeout", int'(done), 1);
  endtask

  task automatic run_one(input int a, input int b, input int q,
                         input int r, input int dbz);
    push_op(a, b, q, r, dbz);
    @(negedge clk);
    start = 1'b0;
    wait_done();
    @(negedge clk);
  endtask

  initial begin
    int busy_cnt;
    int busy_seen;

    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_quotient", int'(quotient), 0);
    check("rst_remainder", int'(remainder), 0);
    check("rst_dbz", int'(div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 13 / 4 with busy width
    push_op(13, 4, 3, 1, 0);
    busy_cnt = 0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    check("busy_cycles_13_4", busy_cnt, 4);
    @(negedge clk);

    run_one(15, 1, 15, 0, 0);
    run_one(3, 7, 0, 3, 0);
    run_one(15, 15, 1, 0, 0);

    // divide by zero, then a normal op clears the flag
    push_op(9, 0, 15, 9, 1);
    busy_seen = 0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (busy) busy_seen = 1;
      @(negedge clk);
    end
    if (busy) busy_seen = 1;
    check("busy_seen_div0", busy_seen, 0);
    @(negedge clk);
    run_one(8, 2, 4, 0, 0);

    // start during RUN is ignored
    push_op(12, 5, 2, 2, 0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start    = 1'b1;
    dividend = 4'd15;
    divisor  = 4'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (8) @(negedge clk);

    // async reset mid-RUN
    push_op(13, 4, 3, 1, 0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrun_busy", int'(busy), 0);
    check("midrun_done", int'(done), 0);
    check("midrun_quotient", int'(quotient), 0);
    check("midrun_remainder", int'(remainder), 0);
    check("midrun_dbz", int'(div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_one(7, 2, 3, 1, 0);

    // exhaustive sweep, start re-asserted in each done cycle
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) push_op(a, b, 15, a, 1);
        else push_op(a, b, a / b, a % b, 0);
        @(negedge clk);
        wait_done();
      end
    end
    start = 1'b0;
    repeat (8) @(negedge clk);

    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
